// File: rtl/store_narrow.sv
// Store narrowing stage: formats SW/SH/SB into word address, replicated data and byte enables,
// buffers them in a DEPTH-entry FIFO and pulses ades on rejects. Optional macro: STORE_NARROW_CNT_EN.
module store_narrow #(
    parameter int DEPTH = 2,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [31:0]   in_data,
    input  logic [1:0]    in_sop,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic          ades,
    output logic          idle
`ifdef STORE_NARROW_CNT_EN
    ,
    output logic [31:0]   st_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
    logic [AW-1:0] addr_q  [DEPTH];
    logic [AW-1:0] addr_d  [DEPTH];
    logic [31:0]   wdata_q [DEPTH];
    logic [31:0]   wdata_d [DEPTH];
    logic [3:0]    be_q    [DEPTH];
    logic [3:0]    be_d    [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ades_q, ades_d;

    logic [31:0] fmt_wdata;
    logic [3:0]  fmt_be;
    logic        reject;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        fmt_wdata = in_data;
        fmt_be    = 4'b1111;
        reject    = 1'b0;
        case (in_sop)
            2'd0: begin
                reject = (in_addr[1:0] != 2'b00);
            end
            2'd1: begin
                fmt_wdata = {2{in_data[15:0]}};
                fmt_be    = in_addr[1] ? 4'b1100 : 4'b0011;
                reject    = in_addr[0];
            end
            2'd2: begin
                fmt_wdata = {4{in_data[7:0]}};
                fmt_be    = 4'b0001 << in_addr[1:0];
            end
            default: begin
                reject = 1'b1;
            end
        endcase
    end

    assign in_ready  = (count_q != FULL_CNT);
    assign mem_valid = (count_q != '0);
    assign idle      = (count_q == '0);
    assign accept    = in_valid && in_ready;
    // Rejected requests complete the handshake but never reach the FIFO.
    assign push      = accept && !reject;
    assign pop       = mem_valid && mem_ready;
    assign ades      = ades_q;

    assign mem_addr  = mem_valid ? addr_q[rd_ptr_q]  : '0;
    assign mem_wdata = mem_valid ? wdata_q[rd_ptr_q] : '0;
    assign mem_be    = mem_valid ? be_q[rd_ptr_q]    : '0;

    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ades_d   = accept && reject;
        if (push) begin
            addr_d[wr_ptr_q]  = {in_addr[AW-1:2], 2'b00};
            wdata_d[wr_ptr_q] = fmt_wdata;
            be_d[wr_ptr_q]    = fmt_be;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                wdata_q[i] <= '0;
                be_q[i]    <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ades_q   <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ades_q   <= ades_d;
        end
    end

`ifdef STORE_NARROW_CNT_EN
    logic [31:0] st_count_q, st_count_d;

    // Counts completed memory writes only; wraps naturally at 2^32.
    always_comb begin
        st_count_d = st_count_q;
        if (pop) begin
            st_count_d = st_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_count_q <= '0;
        end else begin
            st_count_q <= st_count_d;
        end
    end

    assign st_count = st_count_q;
`endif

endmodule

// File: tb/tb_store_narrow.sv
// Bench for store_narrow: vector table for formatting/rejects, plus sequences for
// back-to-back rejects, backpressure, streaming wrap and asynchronous reset.
module tb_store_narrow;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_sop;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        ades;
  logic        idle;
`ifdef STORE_NARROW_CNT_EN
  logic [31:0] st_count;
`endif

  store_narrow #(.DEPTH(2), .AW(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_sop    (in_sop),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .ades      (ades),
    .idle      (idle)
`ifdef STORE_NARROW_CNT_EN
    ,
    .st_count  (st_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  bit mon_en;
  int push_waits;
  logic [67:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sop;
    logic        rej;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every pop must match the oldest accepted store
  always @(negedge clk) begin
    if (mon_en && reset_n && mem_valid && mem_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop: got %08h/%08h/%h with nothing expected", mem_addr, mem_wdata, mem_be);
      end else begin
        if ({mem_addr, mem_wdata, mem_be} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL pop_order: got %08h/%08h/%h expected %08h/%08h/%h",
                   mem_addr, mem_wdata, mem_be, exp_q[0][67:36], exp_q[0][35:4], exp_q[0][3:0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  // driver: called at posedge+2, returns at posedge+2 after the accepting edge
  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input logic [31:0] ew, input logic [3:0] eb);
    int  waited;
    bit  done;
    logic rdy;
    waited = 0;
    done = 0;
    in_valid = 1'b1;
    in_addr = a;
    in_data = d;
    in_sop = s;
    while (!done) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back({a[31:2], 2'b00, ew, eb});
        done = 1;
      end else begin
        waited++;
        push_waits++;
        if (waited > 50) begin
          n_checks++;
          n_fail++;
          $display("FAIL push_timeout: in_ready=0 for %0d cycles, required 1", waited);
          done = 1;
        end
      end
    end
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      @(posedge clk);
      cyc++;
    end
    #2;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mon_en = 0;
    push_waits = 0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_addr = '0;
    in_data = '0;
    in_sop = '0;
    mem_ready = 1'b0;

    vecs[0]  = '{32'h0000_1000, 32'hDEAD_BEEF, 2'd0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'b1111};
    vecs[1]  = '{32'h0000_2001, 32'h0000_00A5, 2'd2, 1'b0, 32'h0000_2000, 32'hA5A5_A5A5, 4'b0010};
    vecs[2]  = '{32'h0000_2003, 32'h0000_00A5, 2'd2, 1'b0, 32'h0000_2000, 32'hA5A5_A5A5, 4'b1000};
    vecs[3]  = '{32'h0000_3002, 32'h1234_CAFE, 2'd1, 1'b0, 32'h0000_3000, 32'hCAFE_CAFE, 4'b1100};
    vecs[4]  = '{32'h0000_3001, 32'h1234_CAFE, 2'd1, 1'b1, 32'h0,        32'h0,         4'b0000};
    vecs[5]  = '{32'h0000_4000, 32'hBEEF_1357, 2'd1, 1'b0, 32'h0000_4000, 32'h1357_1357, 4'b0011};
    vecs[6]  = '{32'h0000_5000, 32'h1122_3344, 2'd2, 1'b0, 32'h0000_5000, 32'h4444_4444, 4'b0001};
    vecs[7]  = '{32'h0000_5002, 32'h0000_0099, 2'd2, 1'b0, 32'h0000_5000, 32'h9999_9999, 4'b0100};
    vecs[8]  = '{32'h0000_6002, 32'h5555_AAAA, 2'd0, 1'b1, 32'h0,        32'h0,         4'b0000};
    vecs[9]  = '{32'h0000_7000, 32'h5555_AAAA, 2'd3, 1'b1, 32'h0,        32'h0,         4'b0000};
    vecs[10] = '{32'hFFFF_FFFC, 32'h0123_4567, 2'd0, 1'b0, 32'hFFFF_FFFC, 32'h0123_4567, 4'b1111};
    vecs[11] = '{32'h0000_8003, 32'h0000_FFFF, 2'd1, 1'b1, 32'h0,        32'h0,         4'b0000};

    #12;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_idle", idle, 1);
    check("rst_in_ready", in_ready, 1);
    check("rst_ades", ades, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", mem_be, 0);
`ifdef STORE_NARROW_CNT_EN
    check("rst_st_count", st_count, 0);
`endif

    // formatting / reject table, one store at a time with memory ready
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      mem_ready = 1'b1;
      in_valid = 1'b1;
      in_addr = vecs[i].addr;
      in_data = vecs[i].data;
      in_sop = vecs[i].sop;
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(posedge clk); #2;
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_ades", i), ades, vecs[i].rej);
      check($sformatf("v%0d_mem_valid", i), mem_valid, !vecs[i].rej);
      check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d_mem_be", i), mem_be, vecs[i].e_be);
      @(posedge clk); #2;
      @(negedge clk);
      check($sformatf("v%0d_idle_after", i), idle, 1);
      check($sformatf("v%0d_ades_after", i), ades, 0);
      check($sformatf("v%0d_wdata_after", i), mem_wdata, 0);
    end

    // back-to-back rejects: reserved sop then misaligned SW
    @(posedge clk); #2;
    in_valid = 1'b1;
    in_sop = 2'd3;
    in_addr = 32'h0000_9000;
    @(posedge clk); #2;
    in_sop = 2'd0;
    in_addr = 32'h0000_9001;
    @(negedge clk);
    check("b2b_ades_1", ades, 1);
    check("b2b_valid_1", mem_valid, 0);
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_ades_2", ades, 1);
    check("b2b_valid_2", mem_valid, 0);
    @(posedge clk); #2;
    @(negedge clk);
    check("b2b_ades_3", ades, 0);
    check("b2b_idle", idle, 1);

    // backpressure: fill with A, B, then C waits until space frees up
    mon_en = 1;
    mem_ready = 1'b0;
    @(posedge clk); #2;
    push(32'h0000_A000, 32'hAAAA_0001, 2'd0, 32'hAAAA_0001, 4'b1111);
    push(32'h0000_B000, 32'hBBBB_0002, 2'd0, 32'hBBBB_0002, 4'b1111);
    in_valid = 1'b1;
    in_addr = 32'h0000_C000;
    in_data = 32'hCCCC_0003;
    in_sop = 2'd0;
    @(negedge clk);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_head_a_1", mem_wdata, 32'hAAAA_0001);
    @(posedge clk); #2;
    @(negedge clk);
    check("bp_in_ready_full_2", in_ready, 0);
    check("bp_head_a_2", mem_wdata, 32'hAAAA_0001);
    check("bp_head_addr", mem_addr, 32'h0000_A000);
    @(posedge clk); #2;
    mem_ready = 1'b1;
    push(32'h0000_C000, 32'hCCCC_0003, 2'd0, 32'hCCCC_0003, 4'b1111);
    drain("bp_drain");
    @(negedge clk);
    check("bp_idle", idle, 1);

    // streaming with concurrent push/pop through pointer wrap
    @(posedge clk); #2;
    push_waits = 0;
    for (int i = 0; i < 8; i++) begin
      push(32'h0000_0100 + 32'(i * 4), 32'h1000_0000 + 32'(i), 2'd0, 32'h1000_0000 + 32'(i), 4'b1111);
    end
    check("stream_no_stall", push_waits, 0);
    @(negedge clk); #1;
    check("stream_one_per_cycle", exp_q.size(), 0);
    @(posedge clk); #2;
    @(negedge clk);
    check("stream_idle", idle, 1);
`ifdef STORE_NARROW_CNT_EN
    check("st_count_total", st_count, 19);
`endif

    // asynchronous reset with two entries pending
    mem_ready = 1'b0;
    @(posedge clk); #2;
    push(32'h0000_D000, 32'hD0D0_D0D0, 2'd0, 32'hD0D0_D0D0, 4'b1111);
    push(32'h0000_E000, 32'hE0E0_E0E0, 2'd0, 32'hE0E0_E0E0, 4'b1111);
    @(negedge clk);
    check("pre_rst_valid", mem_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("amid_rst_valid", mem_valid, 0);
    check("amid_rst_idle", idle, 1);
    check("amid_rst_in_ready", in_ready, 1);
    check("amid_rst_be", mem_be, 0);
`ifdef STORE_NARROW_CNT_EN
    check("amid_rst_st_count", st_count, 0);
`endif
    #1;
    reset_n = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk); #2;
    push(32'h0000_F003, 32'h0000_005A, 2'd2, 32'h5A5A_5A5A, 4'b1000);
    drain("post_rst_drain");
    @(negedge clk);
    check("post_rst_idle", idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

endmodule
